// File: rtl/exe_issue_seq_pkg.sv
// Shared constants for the ID->EX issue sequencer: the NOP word, cycle-count
// encodings and the opcode field patterns used to classify multi-cycle ops.
package exe_issue_seq_pkg;

    // MOV r0,r0: what execute sees whenever nothing real is issued.
    localparam logic [31:0] NOP_WORD = 32'hE1A00000;

    // Number of execute cycles an instruction occupies, stored as ncyc.
    localparam logic [1:0] CYC1 = 2'd1;
    localparam logic [1:0] CYC2 = 2'd2;
    localparam logic [1:0] CYC3 = 2'd3;

    // Long multiply: [27:23] = 00001 and [7:4] = 1001; [21] selects accumulate.
    localparam logic [4:0] MULL_HI_PAT = 5'b00001;
    localparam logic [3:0] MUL_LO_PAT  = 4'b1001;
    localparam int         MULL_ACC_BIT = 21;

    // Single data transfer: [27:26] = 01. Writeback happens when W ([21]) is
    // set or when the access is post-indexed (P, [24], clear).
    localparam logic [1:0] SDT_PAT    = 2'b01;
    localparam int         SDT_W_BIT  = 21;
    localparam int         SDT_P_BIT  = 24;

    // Instruction groups that differ in execute-cycle count.
    typedef enum logic [1:0] {
        CLS_SINGLE = 2'd0,
        CLS_MULL   = 2'd1,
        CLS_MLAL   = 2'd2,
        CLS_SDT_WB = 2'd3
    } op_class_e;

    // Map an instruction group onto its execute-cycle count.
    function automatic logic [1:0] class_cycles(input op_class_e cls);
        logic [1:0] cyc;
        case (cls)
            CLS_MULL:   cyc = CYC2;
            CLS_MLAL:   cyc = CYC3;
            CLS_SDT_WB: cyc = CYC2;
            default:    cyc = CYC1;
        endcase
        return cyc;
    endfunction

endpackage

// File: rtl/exe_cycle_class.sv
// Pure combinational classifier: instruction word -> execute-cycle count.
// Kept separate so hazard logic can reuse the same decode.
module exe_cycle_class
    import exe_issue_seq_pkg::*;
#(
    parameter int OPW = 32
) (
    input  logic [OPW-1:0] opcode,
    output logic [1:0]     ncyc
);

    logic      is_mull;
    logic      is_sdt_wb;
    op_class_e cls;

    assign is_mull   = (opcode[27:23] == MULL_HI_PAT) && (opcode[7:4] == MUL_LO_PAT);
    assign is_sdt_wb = (opcode[27:26] == SDT_PAT) &&
                       (opcode[SDT_W_BIT] || !opcode[SDT_P_BIT]);

    // Pick the instruction group; multiply-long is checked first so its
    // pattern can never be mistaken for a transfer.
    always_comb begin
        // NOTE: default assignment first so every path drives cls and no latch is inferred.
        cls = CLS_SINGLE;
        if (is_mull) begin
            cls = opcode[MULL_ACC_BIT] ? CLS_MLAL : CLS_MULL;
        end else if (is_sdt_wb) begin
            cls = CLS_SDT_WB;
        end
    end

    assign ncyc = class_cycles(cls);

endmodule

// File: rtl/exe_issue_seq.sv
// ID->EX pipeline register plus multi-cycle phase sequencer feeding the
// execute control ROM. Produces the GCnt/GCnt2 phase strobes and holds decode
// off while a multi-cycle instruction is still running.
module exe_issue_seq
    import exe_issue_seq_pkg::*;
#(
    parameter int             OPW      = 32,
    parameter logic [OPW-1:0] NOP_WORD = exe_issue_seq_pkg::NOP_WORD
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] ID_OPCODE,
    input  logic           ID_VALID,
    input  logic           FLUSH,
    input  logic           MEM_STALL,
    output logic [OPW-1:0] EX_OPCODE,
    output logic           EX_VALID,
    output logic           GCnt,
    output logic           GCnt2,
    output logic           EX_LAST,
    output logic           ID_STALL
);

    // Phase counter states; the counter only walks up to ncyc-1.
    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;

    logic [OPW-1:0] ex_opcode_q;
    logic           ex_valid_q;
    logic [1:0]     phase_q;
    logic [1:0]     ncyc_q;
    logic [1:0]     id_ncyc;
    logic [1:0]     load_ncyc;
    logic [1:0]     phase_next;
    logic           ex_last;
    logic           advance;

    exe_cycle_class #(
        .OPW (OPW)
    ) u_cycle_class (
        .opcode (ID_OPCODE),
        .ncyc   (id_ncyc)
    );

    // A bubble always takes exactly one cycle, whatever its opcode bits say.
    assign load_ncyc = ID_VALID ? id_ncyc : CYC1;

    // Final phase of the current instruction; a bubble (ncyc=1) is always last.
    assign ex_last = (phase_q == (ncyc_q - 2'd1));

    // Still inside a multi-cycle instruction: step the phase instead of loading.
    assign advance = ex_valid_q && !ex_last;

    // Successor phase while advancing; saturates at P2 so it can never run
    // past the longest instruction even if ncyc were corrupted.
    always_comb begin
        phase_next = P0;
        case (phase_q)
            P0:      phase_next = P1;
            P1:      phase_next = P2;
            default: phase_next = P2;
        endcase
    end

    // Pipeline register and phase counter: flush > mem stall > advance > load.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_opcode_q <= NOP_WORD;
            ex_valid_q  <= 1'b0;
            phase_q     <= P0;
            ncyc_q      <= CYC1;
        end else if (FLUSH) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ex_opcode_q <= NOP_WORD;
            ex_valid_q  <= 1'b0;
            phase_q     <= P0;
            ncyc_q      <= CYC1;
        end else if (MEM_STALL) begin
            ex_opcode_q <= ex_opcode_q;
            ex_valid_q  <= ex_valid_q;
            phase_q     <= phase_q;
            ncyc_q      <= ncyc_q;
        end else if (advance) begin
            phase_q     <= phase_next;
        end else begin
            ex_opcode_q <= ID_VALID ? ID_OPCODE : NOP_WORD;
            ex_valid_q  <= ID_VALID;
            phase_q     <= P0;
            ncyc_q      <= load_ncyc;
        end
    end

    // Strobes decoded from registers only, so execute sees them glitch-free
    // at the start of the cycle with no path from this cycle's inputs.
    assign EX_OPCODE = ex_opcode_q;
    assign EX_VALID  = ex_valid_q;
    assign GCnt      = (phase_q != P0);
    assign GCnt2     = (phase_q == P2);
    assign EX_LAST   = ex_last;
    assign ID_STALL  = advance;

endmodule

// File: tb/tb_exe_issue_seq.sv
// Self-checking bench for exe_issue_seq: directed scenarios plus a randomized
// run compared cycle by cycle against an instruction-level reference model.
module tb_exe_issue_seq;

    localparam logic [31:0] NOP   = 32'hE1A00000;
    localparam logic [31:0] ADD   = 32'hE0810002;
    localparam logic [31:0] SUB   = 32'hE0410002;
    localparam logic [31:0] UMULL = 32'hE0821394;
    localparam logic [31:0] UMLAL = 32'hE0A21394;
    localparam logic [31:0] LDRPW = 32'hE5B10004;
    localparam logic [31:0] LDRP  = 32'hE5910004;
    localparam logic [31:0] LDRPO = 32'hE4910004;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] ID_OPCODE = 32'h0;
    logic        ID_VALID = 1'b0;
    logic        FLUSH = 1'b0;
    logic        MEM_STALL = 1'b0;
    logic [31:0] EX_OPCODE;
    logic        EX_VALID, GCnt, GCnt2, EX_LAST, ID_STALL;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the instruction in EX, its total cycle count and
    // which of those cycles is currently showing.
    logic [31:0] m_op;
    logic        m_valid;
    int          m_total;
    int          m_idx;

    exe_issue_seq dut (
        .CLK       (CLK),
        .RST       (RST),
        .ID_OPCODE (ID_OPCODE),
        .ID_VALID  (ID_VALID),
        .FLUSH     (FLUSH),
        .MEM_STALL (MEM_STALL),
        .EX_OPCODE (EX_OPCODE),
        .EX_VALID  (EX_VALID),
        .GCnt      (GCnt),
        .GCnt2     (GCnt2),
        .EX_LAST   (EX_LAST),
        .ID_STALL  (ID_STALL)
    );

    always #5 CLK = ~CLK;

    // Observed outputs packed as {op, valid, gcnt, gcnt2, last, stall}.
    wire [36:0] obs = {EX_OPCODE, EX_VALID, GCnt, GCnt2, EX_LAST, ID_STALL};

    function automatic logic [36:0] pk(input logic [31:0] op, input logic v, g, g2, l, s);
        return {op, v, g, g2, l, s};
    endfunction

    // Execute cycles an instruction needs, straight from the ISA rules.
    function automatic int ref_cycles(input logic [31:0] w, input logic v);
        if (!v) return 1;
        if (w[27:23] == 5'b00001 && w[7:4] == 4'b1001) return w[21] ? 3 : 2;
        if (w[27:26] == 2'b01 && (w[21] || !w[24])) return 2;
        return 1;
    endfunction

    function automatic logic [36:0] model_exp();
        logic last;
        last = (m_idx == m_total - 1);
        return pk(m_op, m_valid, m_idx >= 1, m_idx == 2, last, m_valid && !last);
    endfunction

    task automatic model_reset();
        m_op = NOP; m_valid = 1'b0; m_total = 1; m_idx = 0;
    endtask

    task automatic model_clock(input logic [31:0] op, input logic v, f, s);
        if (f) begin
            model_reset();
        end else if (s) begin
            // hold
        end else if (m_valid && m_idx < m_total - 1) begin
            m_idx = m_idx + 1;
        end else begin
            m_op = v ? op : NOP; m_valid = v; m_total = ref_cycles(op, v); m_idx = 0;
        end
    endtask

    // One clock: drive at negedge, model follows the posedge, return at negedge.
    task automatic step(input logic [31:0] op, input logic v, f, s);
        ID_OPCODE = op; ID_VALID = v; FLUSH = f; MEM_STALL = s;
        @(posedge CLK);
        model_clock(op, v, f, s);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        n_cmp++;
        if (obs !== pk(NOP, 0, 0, 0, 1, 0)) begin
            n_err++; $display("FAIL reset_state: got %h expected %h", obs, pk(NOP, 0, 0, 0, 1, 0));
        end
    endtask

    task automatic test_back_to_back();
        step(ADD, 1, 0, 0);
        n_cmp++;
        if (obs !== pk(ADD, 1, 0, 0, 1, 0)) begin
            n_err++; $display("FAIL b2b_add: got %h expected %h", obs, pk(ADD, 1, 0, 0, 1, 0));
        end
        step(SUB, 1, 0, 0);
        n_cmp++;
        if (obs !== pk(SUB, 1, 0, 0, 1, 0)) begin
            n_err++; $display("FAIL b2b_sub: got %h expected %h", obs, pk(SUB, 1, 0, 0, 1, 0));
        end
        step(UMLAL, 0, 0, 0);
        n_cmp++;
        if (obs !== pk(NOP, 0, 0, 0, 1, 0)) begin
            n_err++; $display("FAIL bubble: got %h expected %h", obs, pk(NOP, 0, 0, 0, 1, 0));
        end
    endtask

    task automatic test_mull();
        step(UMULL, 1, 0, 0);
        n_cmp++;
        if (obs !== pk(UMULL, 1, 0, 0, 0, 1)) begin
            n_err++; $display("FAIL mull_c0: got %h expected %h", obs, pk(UMULL, 1, 0, 0, 0, 1));
        end
        step(ADD, 1, 0, 0);
        n_cmp++;
        if (obs !== pk(UMULL, 1, 1, 0, 1, 0)) begin
            n_err++; $display("FAIL mull_c1: got %h expected %h", obs, pk(UMULL, 1, 1, 0, 1, 0));
        end
        step(ADD, 1, 0, 0);
        n_cmp++;
        if (obs !== pk(ADD, 1, 0, 0, 1, 0)) begin
            n_err++; $display("FAIL mull_next: got %h expected %h", obs, pk(ADD, 1, 0, 0, 1, 0));
        end
    endtask

    task automatic test_mlal();
        logic [36:0] exp_seq [3];
        exp_seq[0] = pk(UMLAL, 1, 0, 0, 0, 1);
        exp_seq[1] = pk(UMLAL, 1, 1, 0, 0, 1);
        exp_seq[2] = pk(UMLAL, 1, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(i == 0 ? UMLAL : SUB, 1, 0, 0);
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_err++; $display("FAIL mlal_c%0d: got %h expected %h", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_sdt();
        step(LDRPW, 1, 0, 0);
        n_cmp++;
        if (obs !== pk(LDRPW, 1, 0, 0, 0, 1)) begin
            n_err++; $display("FAIL ldr_prewb_c0: got %h expected %h", obs, pk(LDRPW, 1, 0, 0, 0, 1));
        end
        step(LDRP, 1, 0, 0);
        n_cmp++;
        if (obs !== pk(LDRPW, 1, 1, 0, 1, 0)) begin
            n_err++; $display("FAIL ldr_prewb_c1: got %h expected %h", obs, pk(LDRPW, 1, 1, 0, 1, 0));
        end
        step(LDRP, 1, 0, 0);
        n_cmp++;
        if (obs !== pk(LDRP, 1, 0, 0, 1, 0)) begin
            n_err++; $display("FAIL ldr_pre: got %h expected %h", obs, pk(LDRP, 1, 0, 0, 1, 0));
        end
        step(LDRPO, 1, 0, 0);
        n_cmp++;
        if (obs !== pk(LDRPO, 1, 0, 0, 0, 1)) begin
            n_err++; $display("FAIL ldr_post_c0: got %h expected %h", obs, pk(LDRPO, 1, 0, 0, 0, 1));
        end
        step(NOP, 0, 0, 0);
        n_cmp++;
        if (obs !== pk(LDRPO, 1, 1, 0, 1, 0)) begin
            n_err++; $display("FAIL ldr_post_c1: got %h expected %h", obs, pk(LDRPO, 1, 1, 0, 1, 0));
        end
    endtask

    task automatic test_stall_flush();
        step(UMLAL, 1, 0, 0);
        step(ADD, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(ADD, 1, 0, 1);
            n_cmp++;
            if (obs !== pk(UMLAL, 1, 1, 0, 0, 1)) begin
                n_err++; $display("FAIL stall_hold%0d: got %h expected %h", i, obs, pk(UMLAL, 1, 1, 0, 0, 1));
            end
        end
        step(ADD, 1, 1, 1);
        n_cmp++;
        if (obs !== pk(NOP, 0, 0, 0, 1, 0)) begin
            n_err++; $display("FAIL flush_over_stall: got %h expected %h", obs, pk(NOP, 0, 0, 0, 1, 0));
        end
    endtask

    task automatic test_async_reset();
        step(UMLAL, 1, 0, 0);
        step(ADD, 1, 0, 0);
        n_cmp++;
        if (obs !== pk(UMLAL, 1, 1, 0, 0, 1)) begin
            n_err++; $display("FAIL pre_reset_p1: got %h expected %h", obs, pk(UMLAL, 1, 1, 0, 0, 1));
        end
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if (obs !== pk(NOP, 0, 0, 0, 1, 0)) begin
            n_err++; $display("FAIL async_reset: got %h expected %h", obs, pk(NOP, 0, 0, 0, 1, 0));
        end
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        step(ADD, 1, 0, 0);
        n_cmp++;
        if (obs !== pk(ADD, 1, 0, 0, 1, 0)) begin
            n_err++; $display("FAIL post_reset_load: got %h expected %h", obs, pk(ADD, 1, 0, 0, 1, 0));
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] op;
        logic        v, f, s;
        pool[0] = ADD; pool[1] = SUB; pool[2] = UMULL; pool[3] = UMLAL;
        pool[4] = LDRPW; pool[5] = LDRP; pool[6] = LDRPO; pool[7] = 32'hE4B10004;
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 7)];
            v  = ($urandom_range(0, 9) < 7);
            f  = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 6) == 0);
            step(op, v, f, s);
            n_cmp++;
            if (obs !== model_exp()) begin
                n_err++; $display("FAIL random_%0d: got %h expected %h", i, obs, model_exp());
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        test_reset();
        RST = 1'b0;
        test_back_to_back();
        test_mull();
        test_mlal();
        test_sdt();
        test_stall_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exe_issue_seq.md
Name: exe_issue_seq

Overview:
- ID→EX pipeline register plus multi-cycle sequencer sitting directly upstream of the execute-stage control ROM.
- Latches the decoded instruction word and presents it to execute as EX_OPCODE.
- Generates the phase strobes GCnt/GCnt2 that the execute control ROM uses to split long multiplies and write-back loads/stores into multiple execute cycles.
- Back-pressures decode while a multi-cycle instruction is in progress.

Parameters:
- OPW, 32, instruction word width.
- NOP_WORD, 32'hE1A00000, word loaded into EX_OPCODE on reset or flush (MOV r0,r0).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- ID_OPCODE  input  OPW  instruction word from decode.
- ID_VALID  input  1  ID_OPCODE holds a real instruction.
- FLUSH  input  1  branch taken; kill the instruction in EX.
- MEM_STALL  input  1  downstream hold; freeze all state.
- EX_OPCODE  output  OPW  instruction presented to execute stage.
- EX_VALID  output  1  EX_OPCODE is live.
- GCnt  output  1  high in phase 1 and phase 2.
- GCnt2  output  1  high in phase 2 only.
- EX_LAST  output  1  current phase is the final one for this instruction.
- ID_STALL  output  1  decode must hold ID_OPCODE/ID_VALID.

Behaviour:
- Clock and reset: one clock, CLK; RST is asynchronous and active-high.
- Reset values: EX_OPCODE=NOP_WORD, EX_VALID=0, phase=0, ncyc=1, GCnt=0, GCnt2=0, EX_LAST=1, ID_STALL=0. Reset asserted mid-sequence aborts immediately, with no completion cycle.
- Cycle class is computed from ID_OPCODE at latch time and stored as ncyc (2 bits):
  - MULL: [27:23]=00001, [7:4]=1001, [21]=0 → 2 cycles.
  - MLAL: same pattern with [21]=1 → 3 cycles.
  - Single data transfer with writeback: [27:26]=01 and ([21]=1 or [24]=0) → 2 cycles.
  - All other instructions, and ID_VALID=0 → 1 cycle.
- Phase counter states: P0, P1, P2.
  - GCnt = (phase!=0).
  - GCnt2 = (phase==2).
  - EX_LAST = (phase==ncyc-1).
  - All three are decoded from registers only; no combinational path from inputs.
- ID_STALL = EX_VALID & ~EX_LAST, combinational from registers. MEM_STALL is not folded into ID_STALL; decode receives MEM_STALL separately.
- Per-edge priority, highest first:
  1. FLUSH: EX_OPCODE←NOP_WORD, EX_VALID←0, phase←0, ncyc←1. ID_OPCODE is discarded that cycle.
  2. MEM_STALL: all state holds.
  3. EX_VALID & ~EX_LAST: phase←phase+1; EX_OPCODE holds.
  4. Otherwise (load): EX_OPCODE←ID_VALID?ID_OPCODE:NOP_WORD, EX_VALID←ID_VALID, phase←0, ncyc←class.
- Latency: an accepted instruction appears on EX_OPCODE one cycle after ID_VALID is sampled; back-to-back 1-cycle instructions give full throughput.
- Phase never exceeds ncyc-1. There is no wrap; the transition P(ncyc-1)→P0 happens only on a load.
- FLUSH together with MEM_STALL: flush wins.
- ID_VALID=0 with ncyc=1 produces a bubble: EX_VALID=0, GCnt=0.

Decomposition:
- Shared package holds:
  - NOP_WORD.
  - Cycle-count constants CYC1/CYC2/CYC3.
  - Opcode field masks/patterns for MUL-long and single data transfer.
- One sub-module, exe_cycle_class: pure combinational, ID_OPCODE → ncyc[1:0]. It is reusable by hazard logic.

Test Plan:
1. RST pulse mid-MLAL (phase 1) → asynchronously EX_VALID=0, GCnt=0, GCnt2=0, EX_OPCODE=E1A00000, ID_STALL=0.
2. ADD E0810002 then SUB E0410002 back-to-back, ID_VALID=1 → EX_OPCODE shows each for one cycle; GCnt=0; ID_STALL=0 throughout.
3. UMULL E0821394 → two EX cycles: GCnt 0,1; GCnt2 0,0; ID_STALL 1,0; EX_LAST 0,1; next instruction loads on cycle 3.
4. UMLAL E0A21394 → three EX cycles: GCnt 0,1,1; GCnt2 0,0,1; ID_STALL 1,1,0.
5. LDR E5B10004 (pre-index writeback) → 2 cycles, GCnt 0,1. LDR E5910004 → 1 cycle. LDR E4910004 (post-index) → 2 cycles.
6. During UMLAL phase 1:
   - MEM_STALL=1 for 2 cycles → phase and GCnt hold at 1.
   - Then FLUSH=1 with MEM_STALL=1 → next cycle EX_VALID=0, EX_OPCODE=E1A00000, GCnt=0, ID_STALL=0.
